// File: rtl/alu_op_arbiter.sv
// Two-requester arbiter that issues one op at a time to four ALU units and returns the result.
// Optional WAIT-state timeout when ALU_OP_ARBITER_TIMEOUT_EN is defined.
module alu_op_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  REQ0_VALID,
    input  logic                  REQ1_VALID,
    output logic                  REQ0_READY,
    output logic                  REQ1_READY,
    input  logic [DATA_WIDTH-1:0] REQ0_A,
    input  logic [DATA_WIDTH-1:0] REQ0_B,
    input  logic [DATA_WIDTH-1:0] REQ1_A,
    input  logic [DATA_WIDTH-1:0] REQ1_B,
    input  logic [3:0]            REQ0_FUN,
    input  logic [3:0]            REQ1_FUN,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    output logic [1:0]            ALU_FUN,
    output logic                  Arith_Enable,
    output logic                  Logic_Enable,
    output logic                  CMP_Enable,
    output logic                  SHIFT_Enable,
    input  logic [DATA_WIDTH-1:0] ARITH_OUT,
    input  logic [DATA_WIDTH-1:0] LOGIC_OUT,
    input  logic [DATA_WIDTH-1:0] CMP_OUT,
    input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
    input  logic                  Arith_Flag,
    input  logic                  Logic_Flag,
    input  logic                  CMP_Flag,
    input  logic                  SHIFT_Flag,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_ID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_ERR
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic                    last_grant;
    logic [1:0]              sel;
    logic                    grant0;
    logic                    grant1;
    logic [DATA_WIDTH-1:0]   g_a;
    logic [DATA_WIDTH-1:0]   g_b;
    logic [3:0]              g_fun;
    logic                    sel_flag;
    logic [DATA_WIDTH-1:0]   sel_out;

    // last_grant == 1 means REQ1 won last, so REQ0 wins the next tie
    assign grant0     = REQ0_VALID && (!REQ1_VALID || last_grant);
    assign grant1     = REQ1_VALID && (!REQ0_VALID || !last_grant);
    assign REQ0_READY = (state == S_IDLE) && grant0;
    assign REQ1_READY = (state == S_IDLE) && grant1;

    assign g_a   = grant1 ? REQ1_A   : REQ0_A;
    assign g_b   = grant1 ? REQ1_B   : REQ0_B;
    assign g_fun = grant1 ? REQ1_FUN : REQ0_FUN;

    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (sel)
            2'b00: begin sel_flag = Arith_Flag; sel_out = ARITH_OUT; end
            2'b01: begin sel_flag = Logic_Flag; sel_out = LOGIC_OUT; end
            2'b10: begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
            2'b11: begin sel_flag = SHIFT_Flag; sel_out = SHIFT_OUT; end
        endcase
    end

`ifdef ALU_OP_ARBITER_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       err_q;
    logic       timeout_hit;

    assign timeout_hit = (wait_cnt == 4'(TIMEOUT_CYCLES - 1));
    assign RSP_ERR     = err_q;
`else
    assign RSP_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state        <= S_IDLE;
            last_grant   <= 1'b1;
            sel          <= 2'b00;
            A            <= '0;
            B            <= '0;
            ALU_FUN      <= 2'b00;
            Arith_Enable <= 1'b0;
            Logic_Enable <= 1'b0;
            CMP_Enable   <= 1'b0;
            SHIFT_Enable <= 1'b0;
            RSP_VALID    <= 1'b0;
            RSP_ID       <= 1'b0;
            RSP_DATA     <= '0;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
            wait_cnt     <= 4'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        A            <= g_a;
                        B            <= g_b;
                        ALU_FUN      <= g_fun[1:0];
                        sel          <= g_fun[3:2];
                        RSP_ID       <= grant1;
                        last_grant   <= grant1;
                        Arith_Enable <= (g_fun[3:2] == 2'b00);
                        Logic_Enable <= (g_fun[3:2] == 2'b01);
                        CMP_Enable   <= (g_fun[3:2] == 2'b10);
                        SHIFT_Enable <= (g_fun[3:2] == 2'b11);
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    Arith_Enable <= 1'b0;
                    Logic_Enable <= 1'b0;
                    CMP_Enable   <= 1'b0;
                    SHIFT_Enable <= 1'b0;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
                    wait_cnt     <= 4'd0;
`endif
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (sel_flag) begin
                        RSP_DATA  <= sel_out;
                        RSP_VALID <= 1'b1;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= S_RESP;
                    end
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        RSP_DATA  <= '0;
                        RSP_VALID <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 4'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: cycle-level scoreboard model plus directed vectors.
// Expectations follow ALU_OP_ARBITER_TIMEOUT_EN when it is defined.
module tb_alu_op_arbiter;
    localparam int W   = 16;
    localparam int TMO = 4;
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
    localparam int MUTE_LAT = 2 + TMO;
`else
    localparam int MUTE_LAT = 1 << 30;
`endif

    logic CLK = 1'b0;
    logic rst;
    logic REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
    logic [W-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic [3:0] REQ0_FUN, REQ1_FUN;
    logic [W-1:0] A, B;
    logic [1:0] ALU_FUN;
    logic Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
    logic [W-1:0] u_out [4];
    logic [3:0] u_flag;
    logic RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
    logic [W-1:0] RSP_DATA;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic       mute = 1'b0;
    logic [3:0] noise_mask = 4'b0000;
    logic       late = 1'b0;

    alu_op_arbiter #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .rst(rst),
        .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
        .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
        .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .REQ0_FUN(REQ0_FUN), .REQ1_FUN(REQ1_FUN),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
        .ARITH_OUT(u_out[0]), .LOGIC_OUT(u_out[1]), .CMP_OUT(u_out[2]), .SHIFT_OUT(u_out[3]),
        .Arith_Flag(u_flag[0]), .Logic_Flag(u_flag[1]), .CMP_Flag(u_flag[2]), .SHIFT_Flag(u_flag[3]),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [W-1:0] unit_fn(input logic [1:0] s, input logic [1:0] f,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case ({s, f})
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a + 16'd1;
            4'b0011: r = b - a;
            4'b0100: r = a & b;
            4'b0101: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = ~(a | b);
            4'b1000: r = {15'b0, a == b};
            4'b1001: r = {15'b0, a > b};
            4'b1010: r = {15'b0, a < b};
            4'b1011: r = {15'b0, a != b};
            4'b1100: r = a << b[3:0];
            4'b1101: r = a >> b[3:0];
            4'b1110: r = 16'($signed(a) >>> b[3:0]);
            4'b1111: r = {a[14:0], a[15]};
        endcase
        return r;
    endfunction

    // Unit models: registered result one cycle after enable; noisy units raise stray flags
    always @(posedge CLK) begin
        logic [3:0] en;
        en = {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
        for (int u = 0; u < 4; u++) begin
            if (en[u])
                u_out[u] <= unit_fn(2'(u), ALU_FUN, A, B);
            else if (noise_mask[u] || (late && u == 0))
                u_out[u] <= 16'hBAD0 + 16'(u);
            u_flag[u] <= (en[u] && !mute) || noise_mask[u] || (late && u == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard model: a transaction accepted in cycle m_acc shows its enable in m_acc+1
    // and its response from m_acc+m_lat until handshaken.
    logic         m_busy = 1'b0;
    logic         m_last = 1'b1;
    logic         m_have = 1'b0;
    int           m_acc, m_lat;
    logic [1:0]   m_sel, m_fun;
    logic         m_id, m_err;
    logic [W-1:0] m_a, m_b, m_data;

    always @(negedge CLK) begin
        logic g0, g1, in_resp;
        logic [3:0] exp_en;
        logic [3:0] f;
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_have = 1'b0;
        end else begin
            g0 = !m_busy && REQ0_VALID && (!REQ1_VALID || m_last);
            g1 = !m_busy && REQ1_VALID && !g0;
            check("m_ready0", 32'(REQ0_READY), 32'(g0));
            check("m_ready1", 32'(REQ1_READY), 32'(g1));
            exp_en = (m_busy && cyc == m_acc + 1) ? (4'b0001 << m_sel) : 4'b0000;
            check("m_enables", 32'({SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable}), 32'(exp_en));
            in_resp = m_busy && (cyc >= m_acc + m_lat);
            check("m_rsp_valid", 32'(RSP_VALID), 32'(in_resp));
            if (in_resp) begin
                check("m_rsp_id", 32'(RSP_ID), 32'(m_id));
                check("m_rsp_data", 32'(RSP_DATA), 32'(m_data));
                check("m_rsp_err", 32'(RSP_ERR), 32'(m_err));
            end
            check("m_a", 32'(A), m_have ? 32'(m_a) : 0);
            check("m_b", 32'(B), m_have ? 32'(m_b) : 0);
            check("m_alu_fun", 32'(ALU_FUN), m_have ? 32'(m_fun) : 0);
            if (in_resp && RSP_READY) begin
                m_busy = 1'b0;
            end else if (g0 || g1) begin
                f      = g1 ? REQ1_FUN : REQ0_FUN;
                m_a    = g1 ? REQ1_A : REQ0_A;
                m_b    = g1 ? REQ1_B : REQ0_B;
                m_sel  = f[3:2];
                m_fun  = f[1:0];
                m_id   = g1;
                m_last = g1;
                m_busy = 1'b1;
                m_have = 1'b1;
                m_acc  = cyc;
                if (mute) begin
                    m_lat  = MUTE_LAT;
                    m_data = '0;
                    m_err  = 1'b1;
                end else begin
                    m_lat  = 3;
                    m_data = unit_fn(m_sel, m_fun, m_a, m_b);
                    m_err  = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        if (r == 0) begin
            REQ0_FUN = f; REQ0_A = a; REQ0_B = b; REQ0_VALID = 1'b1;
        end else begin
            REQ1_FUN = f; REQ1_A = a; REQ1_B = b; REQ1_VALID = 1'b1;
        end
    endtask

    task automatic send(input int r, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int acc);
        tick();
        set_req(r, f, a, b);
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if ((r == 0 && REQ0_READY) || (r == 1 && REQ1_READY)) begin
                acc = cyc;
                break;
            end
        end
        check("accept_seen", 32'(acc >= 0), 1);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input int acc, input int budget, output int lat, output int pulses);
        lat = -1;
        pulses = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (Logic_Enable) pulses++;
            if (RSP_VALID) begin
                lat = cyc - acc;
                break;
            end
        end
        check("rsp_seen", 32'(lat >= 0), 1);
    endtask

    typedef struct {
        int         r;
        logic [3:0] f;
        logic [W-1:0] a, b, exp;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int acc, lat, pulses, n;
        int order [4];
        vecs[0] = '{0, 4'b0000, 16'h1234, 16'h0001, 16'h1235};
        vecs[1] = '{1, 4'b0001, 16'h0010, 16'h0020, 16'hFFF0};
        vecs[2] = '{0, 4'b0100, 16'hF0F0, 16'h0FF0, 16'h00F0};
        vecs[3] = '{1, 4'b0111, 16'hF000, 16'h000F, 16'h0FF0};
        vecs[4] = '{0, 4'b1001, 16'h0005, 16'h0003, 16'h0001};
        vecs[5] = '{1, 4'b1000, 16'h0007, 16'h0008, 16'h0000};
        vecs[6] = '{0, 4'b1100, 16'h0001, 16'h0004, 16'h0010};
        vecs[7] = '{1, 4'b1110, 16'h8000, 16'h0004, 16'hF800};
        vecs[8] = '{0, 4'b1101, 16'h8000, 16'h000F, 16'h0001};
        vecs[9] = '{1, 4'b1111, 16'h8001, 16'h0000, 16'h0003};

        rst = 1'b1; RSP_READY = 1'b0;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_A = '0; REQ0_B = '0; REQ1_A = '0; REQ1_B = '0; REQ0_FUN = '0; REQ1_FUN = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge CLK);
        check("rst_rsp_valid", 32'(RSP_VALID), 0);
        check("rst_rsp_data", 32'(RSP_DATA), 0);
        check("rst_rsp_err", 32'(RSP_ERR), 0);
        check("rst_rsp_id", 32'(RSP_ID), 0);
        check("rst_a", 32'(A), 0);
        check("rst_enables", 32'({SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable}), 0);

        // Single logic OR op, then hold RSP_READY low with both requesters pending
        send(0, 4'b0110, 16'h00F0, 16'h0FF0, acc);
        wait_rsp(acc, 20, lat, pulses);
        check("or_latency", 32'(lat), 3);
        check("or_logic_pulses", 32'(pulses), 1);
        check("or_rsp_id", 32'(RSP_ID), 0);
        check("or_rsp_data", 32'(RSP_DATA), 'h0FF0);
        tick();
        set_req(0, 4'b0000, 16'h0001, 16'h0001);
        set_req(1, 4'b0101, 16'h0003, 16'h0005);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("hold_rsp_valid", 32'(RSP_VALID), 1);
            check("hold_rsp_data", 32'(RSP_DATA), 'h0FF0);
            check("hold_ready0", 32'(REQ0_READY), 0);
            check("hold_ready1", 32'(REQ1_READY), 0);
        end
        tick();
        RSP_READY = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        tick();

        // Both requesters pending right after reset: alternate starting with REQ0
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        set_req(0, 4'b0000, 16'h0001, 16'h0002);
        set_req(1, 4'b0101, 16'h00FF, 16'h0F0F);
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge CLK);
            if (REQ0_READY) begin order[n] = 0; n++; end
            else if (REQ1_READY) begin order[n] = 1; n++; end
        end
        check("rr_count", 32'(n), 4);
        check("rr_grant0", 32'(order[0]), 0);
        check("rr_grant1", 32'(order[1]), 1);
        check("rr_grant2", 32'(order[2]), 0);
        check("rr_grant3", 32'(order[3]), 1);
        tick();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (6) tick();

        // REQ1 withdraws while the arbiter is busy and must never be granted
        send(0, 4'b0001, 16'h0005, 16'h0003, acc);
        REQ1_VALID = 1'b1;
        tick();
        REQ1_VALID = 1'b0;
        repeat (6) tick();

        foreach (vecs[k]) begin
            send(vecs[k].r, vecs[k].f, vecs[k].a, vecs[k].b, acc);
            wait_rsp(acc, 20, lat, pulses);
            check("vec_latency", 32'(lat), 3);
            check("vec_rsp_id", 32'(RSP_ID), 32'(vecs[k].r));
            check("vec_rsp_data", 32'(RSP_DATA), 32'(vecs[k].exp));
        end
        repeat (3) tick();

        // Selected unit never answers while the others raise stray flags
        mute = 1'b1;
        noise_mask = 4'b1110;
        send(0, 4'b0000, 16'h1111, 16'h2222, acc);
`ifdef ALU_OP_ARBITER_TIMEOUT_EN
        wait_rsp(acc, 20, lat, pulses);
        check("tmo_latency", 32'(lat), 6);
        check("tmo_rsp_err", 32'(RSP_ERR), 1);
        check("tmo_rsp_data", 32'(RSP_DATA), 0);
        send(0, 4'b0000, 16'h3333, 16'h4444, acc);
        tick();
`else
        repeat (20) @(negedge CLK);
        check("wait_hold_valid", 32'(RSP_VALID), 0);
        tick();
`endif
        // Reset mid-WAIT, then a late flag from the abandoned unit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        late = 1'b1;
        repeat (3) tick();
        late = 1'b0; mute = 1'b0; noise_mask = 4'b0000;
        @(negedge CLK);
        check("late_rsp_valid", 32'(RSP_VALID), 0);
        check("late_rsp_data", 32'(RSP_DATA), 0);
        check("late_rsp_err", 32'(RSP_ERR), 0);
        check("late_a", 32'(A), 0);
        check("late_b", 32'(B), 0);
        check("late_alu_fun", 32'(ALU_FUN), 0);
        tick();
        set_req(0, 4'b0101, 16'h0001, 16'h0002);
        set_req(1, 4'b0000, 16'h0003, 16'h0004);
        n = -1;
        for (int i = 0; i < 5 && n < 0; i++) begin
            @(negedge CLK);
            if (REQ0_READY) n = 0;
            else if (REQ1_READY) n = 1;
        end
        check("post_rst_tie", 32'(n), 0);
        tick();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_op_arbiter.md
ALU_OP_ARBITER -- requirements
Module: alu_op_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4, WAIT-state cycles before error (range 1-15).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports REQ0_VALID / REQ1_VALID  input  1  requester has an op pending.
REQ-006 SHALL have ports REQ0_READY / REQ1_READY  output  1  op accepted this cycle when VALID also high.
REQ-007 SHALL have ports REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  DATA_WIDTH  operands.
REQ-008 SHALL have ports REQ0_FUN / REQ1_FUN  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] unit function.
REQ-009 SHALL have ports A, B  output  DATA_WIDTH  and ALU_FUN  output  2  operands/function to ALU units.
REQ-010 SHALL have ports Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable  output  1  unit enables, one-hot or all zero.
REQ-011 SHALL have ports ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT  input  DATA_WIDTH  registered unit results.
REQ-012 SHALL have ports Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  input  1  unit result-valid flags.
REQ-013 SHALL have ports RSP_VALID  output  1, RSP_READY  input  1, RSP_ID  output  1 (requester index), RSP_DATA  output  DATA_WIDTH, RSP_ERR  output  1 (timeout).

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-015 IDLE: grant = only valid requester; both valid -> requester not granted last; READY high only for grant, only in IDLE.
REQ-016 On VALID&READY SHALL latch A, B, FUN[1:0], unit select, ID into registers and go to ISSUE.
REQ-017 ISSUE: exactly one cycle, selected unit enable high, A/B/ALU_FUN stable; go to WAIT.
REQ-018 WAIT: enables low, A/B/ALU_FUN held; selected unit's flag high -> capture its OUT into RSP_DATA, RSP_ERR=0, go to RESP; non-selected flags ignored.
REQ-019 RESP: RSP_VALID high, RSP_ID/RSP_DATA/RSP_ERR stable until RSP_READY high; on RSP_VALID&RSP_READY go to IDLE.
REQ-020 Accept-to-RSP_VALID latency SHALL be 3 cycles when unit flag arrives on first WAIT cycle.
REQ-021 Last-grant pointer SHALL update only on accept; back-to-back accepts minimum 4 cycles apart (no accept during ISSUE/WAIT/RESP).
REQ-022 Requester deasserting VALID before READY SHALL not be granted; no request stored.

Reset
REQ-023 rst high at rising edge SHALL force IDLE, all enables 0, READY 0, RSP_VALID 0, RSP_ID 0, RSP_DATA 0, RSP_ERR 0, A/B/ALU_FUN 0, last-grant = REQ1 (REQ0 wins first tie), timeout counter 0.
REQ-024 rst mid-operation SHALL abandon in-flight op without response; late unit flags after reset ignored.

Configuration
REQ-025 Macro ALU_OP_ARBITER_TIMEOUT_EN defined: WAIT counts cycles; TIMEOUT_CYCLES elapsed without flag -> RSP_DATA=0, RSP_ERR=1, go to RESP; counter clears on WAIT entry.
REQ-026 Macro not defined: no counter, WAIT held indefinitely, RSP_ERR tied 0.

Verification
REQ-027 Only REQ0 valid, FUN=0110, A=16'h00F0, B=16'h0FF0, logic model returns OR -> RSP_VALID 3 cycles after accept, RSP_ID=0, RSP_DATA=16'h0FF0, Logic_Enable pulsed exactly 1 cycle.
REQ-028 Both valid continuously after reset, 4 ops -> grant order 0,1,0,1.
REQ-029 RSP_READY held low 5 cycles in RESP -> RSP_VALID/RSP_DATA stable 5 cycles, both READY low throughout.
REQ-030 With TIMEOUT_EN, unit model never raises flag, TIMEOUT_CYCLES=4 -> RSP_VALID after 4 WAIT cycles, RSP_ERR=1, RSP_DATA=0; without macro -> stays in WAIT.
REQ-031 rst pulsed during WAIT, then flag raised -> no RSP_VALID, all outputs at reset values, next tie granted to REQ0.
